// File: rtl/gate_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : gate_chk_pkg
//  Purpose : Shared codes and state encoding for the gate response checker.
//  Rev     : 1.0  initial release
// ============================================================================
package gate_chk_pkg;

  // Reference function selectors
  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;

  // Settle counter width; covers SETTLE values 1..15
  localparam int SET_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
//  Module  : gate_ref_model
//  Purpose : Combinational golden model of a 2-input bitwise gate.
//  Rev     : 1.0  initial release
// ============================================================================
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int OP    = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Function chosen at elaboration; unknown codes fall back to AND
  generate
    if (OP == OP_OR) begin : g_or
      assign y = a | b;
    end else if (OP == OP_XOR) begin : g_xor
      assign y = a ^ b;
    end else if (OP == OP_NAND) begin : g_nand
      assign y = ~(a & b);
    end else begin : g_and
      assign y = a & b;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/gate_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module  : gate_resp_checker
//  Purpose : Captures gate operands via valid/ready, waits SETTLE cycles and
//            compares the live gate output against a reference model,
//            accumulating per-run error statistics.
//  Rev     : 1.0  initial release
// ============================================================================
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int OP      = 0,
  parameter int SETTLE  = 2,
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0]     CNT_ONES    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     LAST_IDX    = CNT_W'(NUM_VEC - 1);
  localparam logic [SET_CNT_W-1:0] SETTLE_LOAD = SET_CNT_W'(SETTLE - 1);
  localparam logic [SET_CNT_W-1:0] SET_ONE     = {{(SET_CNT_W-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [WIDTH-1:0]     a_q, b_q, exp_val;
  logic [SET_CNT_W-1:0] settle_cnt;
  logic                 handshake;
  logic                 start_ok;
  logic                 mismatch;

  assign handshake = (state == ST_ARMED) && vec_valid && vec_ready;
  assign start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  // Case-inequality so X/Z on the gate output registers as a failure in simulation
  assign mismatch  = (c !== exp_val);
  assign pass      = done && (err_cnt == '0);

  gate_ref_model #(
    .WIDTH (WIDTH),
    .OP    (OP)
  ) u_ref (
    .a (a_q),
    .b (b_q),
    .y (exp_val)
  );

  // Next-state decode; SETTLE state lasts SETTLE cycles so COMPARE starts SETTLE edges after capture
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_n = ST_ARMED;
      ST_ARMED:         if (vec_valid && vec_ready) state_n = ST_SETTLE;
      ST_SETTLE:        if (settle_cnt == '0) state_n = ST_COMPARE;
      ST_COMPARE:       state_n = (vec_cnt == LAST_IDX) ? ST_DONE : ST_ARMED;
      default:          state_n = ST_IDLE;
    endcase
  end

  // State register and registered status flags derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      vec_ready <= (state_n == ST_ARMED);
      busy      <= (state_n == ST_ARMED) || (state_n == ST_SETTLE) || (state_n == ST_COMPARE);
      done      <= (state_n == ST_DONE);
    end
  end

  // Operand capture and settle countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      settle_cnt <= '0;
    end else if (handshake) begin
      a_q        <= a;
      b_q        <= b;
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SET_ONE;
    end
  end

  // Run statistics: cleared on accepted start, updated once per compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse     <= 1'b0;
      err_cnt       <= '0;
      vec_cnt       <= '0;
      first_err_idx <= CNT_ONES;
    end else begin
      err_pulse <= 1'b0;
      if (start_ok) begin
        err_cnt       <= '0;
        vec_cnt       <= '0;
        first_err_idx <= CNT_ONES;
      end else if (state == ST_COMPARE) begin
        vec_cnt <= vec_cnt + CNT_ONE;
        if (mismatch) begin
          err_pulse <= 1'b1;
          if (err_cnt != CNT_ONES) err_cnt <= err_cnt + CNT_ONE;
          if (first_err_idx == CNT_ONES) first_err_idx <= vec_cnt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module  : tb_gate_resp_checker
//  Purpose : Directed self-checking bench for gate_resp_checker. Four checker
//            instances with different parameters share operands a/b; each
//            sees its own behavioural gate (correct AND, OR, or stuck-at-0).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_gate_resp_checker;

  localparam int SETTLE_OF [4] = '{2, 2, 1, 15};

  logic clk = 1'b0;
  logic rst;
  logic a, b;
  logic start_s [4];
  logic valid_s [4];
  logic c_s     [4];
  int   mode    [4];  // 0 = correct AND gate, 1 = OR gate, 2 = stuck-at-0

  logic       ready_w [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic       pass_w  [4];
  logic       ep_w    [4];
  logic [7:0] ec_w    [4];
  logic [7:0] vc_w    [4];
  logic [7:0] fe_w    [4];
  logic [1:0] ec_2, vc_2, fe_2;

  int checks   = 0;
  int failures = 0;
  int npulse   = 0;
  bit exp_q [$];

  // Free-running clock
  always #5 clk = ~clk;

  // Behavioural gate under check for each instance
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      case (mode[i])
        1:       c_s[i] = a | b;
        2:       c_s[i] = 1'b0;
        default: c_s[i] = a & b;
      endcase
    end
  end

  gate_resp_checker #(.WIDTH(1), .OP(0), .SETTLE(2), .NUM_VEC(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .vec_valid(valid_s[0]), .vec_ready(ready_w[0]),
    .a(a), .b(b), .c(c_s[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_pulse(ep_w[0]), .err_cnt(ec_w[0]), .vec_cnt(vc_w[0]), .first_err_idx(fe_w[0]));

  gate_resp_checker #(.WIDTH(1), .OP(0), .SETTLE(2), .NUM_VEC(3), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .vec_valid(valid_s[1]), .vec_ready(ready_w[1]),
    .a(a), .b(b), .c(c_s[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_pulse(ep_w[1]), .err_cnt(ec_2), .vec_cnt(vc_2), .first_err_idx(fe_2));

  assign ec_w[1] = {6'd0, ec_2};
  assign vc_w[1] = {6'd0, vc_2};
  assign fe_w[1] = {6'd0, fe_2};

  gate_resp_checker #(.WIDTH(1), .OP(0), .SETTLE(1), .NUM_VEC(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .vec_valid(valid_s[2]), .vec_ready(ready_w[2]),
    .a(a), .b(b), .c(c_s[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_pulse(ep_w[2]), .err_cnt(ec_w[2]), .vec_cnt(vc_w[2]), .first_err_idx(fe_w[2]));

  gate_resp_checker #(.WIDTH(1), .OP(0), .SETTLE(15), .NUM_VEC(2), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start_s[3]), .vec_valid(valid_s[3]), .vec_ready(ready_w[3]),
    .a(a), .b(b), .c(c_s[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
    .err_pulse(ep_w[3]), .err_cnt(ec_w[3]), .vec_cnt(vc_w[3]), .first_err_idx(fe_w[3]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input int i);
    @(negedge clk); start_s[i] = 1'b1;
    @(negedge clk); start_s[i] = 1'b0;
  endtask

  // One vector: handshake, push expected mismatch, then check err_pulse is
  // low one cycle early and matches the expectation exactly on time.
  task automatic send(input int i, input logic av, input logic bv, input string tag);
    int   k;
    logic gate_out;
    bit   e;
    @(negedge clk);
    a = av; b = bv; valid_s[i] = 1'b1;
    k = 0;
    while (!ready_w[i] && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, {7'd0, ready_w[i]}, 8'd1);
    gate_out = (mode[i] == 1) ? (av | bv) : (mode[i] == 2) ? 1'b0 : (av & bv);
    exp_q.push_back(gate_out != (av & bv));
    @(posedge clk);
    #1 valid_s[i] = 1'b0;
    repeat (SETTLE_OF[i] + 1) @(negedge clk);
    check({tag, "_early"}, {7'd0, ep_w[i]}, 8'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "_pulse"}, {7'd0, ep_w[i]}, {7'd0, e});
    if (ep_w[i]) npulse++;
  endtask

  task automatic sweep(input int i, input string tag);
    send(i, 1'b0, 1'b0, {tag, "_v0"});
    send(i, 1'b1, 1'b0, {tag, "_v1"});
    send(i, 1'b0, 1'b1, {tag, "_v2"});
    send(i, 1'b1, 1'b1, {tag, "_v3"});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {7'd0, ready_w[0]}, 8'd0);
    check({tag, "_busy"},  {7'd0, busy_w[0]},  8'd0);
    check({tag, "_done"},  {7'd0, done_w[0]},  8'd0);
    check({tag, "_pass"},  {7'd0, pass_w[0]},  8'd0);
    check({tag, "_ep"},    {7'd0, ep_w[0]},    8'd0);
    check({tag, "_ec"},    ec_w[0], 8'd0);
    check({tag, "_vc"},    vc_w[0], 8'd0);
    check({tag, "_fe"},    fe_w[0], 8'hFF);
  endtask

  // Hang guard
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; valid_s[i] = 1'b0; mode[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Correct AND gate: clean pass
    do_start(0);
    check("t1_busy", {7'd0, busy_w[0]}, 8'd1);
    sweep(0, "t1");
    check("t1_done", {7'd0, done_w[0]}, 8'd1);
    check("t1_busy_end", {7'd0, busy_w[0]}, 8'd0);
    check("t1_pass", {7'd0, pass_w[0]}, 8'd1);
    check("t1_ec", ec_w[0], 8'd0);
    check("t1_vc", vc_w[0], 8'd4);
    check("t1_fe", fe_w[0], 8'hFF);

    // OR gate: mismatches at indices 1 and 2
    mode[0] = 1; npulse = 0;
    do_start(0);
    check("t2_done_clr", {7'd0, done_w[0]}, 8'd0);
    sweep(0, "t2");
    check("t2_npulse", 8'(npulse), 8'd2);
    check("t2_ec", ec_w[0], 8'd2);
    check("t2_fe", fe_w[0], 8'd1);
    check("t2_vc", vc_w[0], 8'd4);
    check("t2_done", {7'd0, done_w[0]}, 8'd1);
    check("t2_pass", {7'd0, pass_w[0]}, 8'd0);

    // Idle ARMED, start while busy, then reset mid-settle
    do_start(0);
    repeat (20) @(negedge clk);
    check("t3_busy", {7'd0, busy_w[0]}, 8'd1);
    check("t3_ready", {7'd0, ready_w[0]}, 8'd1);
    check("t3_vc", vc_w[0], 8'd0);
    send(0, 1'b0, 1'b0, "t3_v0");
    send(0, 1'b1, 1'b0, "t3_v1");
    do_start(0);
    check("t3_busy_st", {7'd0, busy_w[0]}, 8'd1);
    check("t3_ec_kept", ec_w[0], 8'd1);
    check("t3_vc_kept", vc_w[0], 8'd2);
    check("t3_fe_kept", fe_w[0], 8'd1);

    @(negedge clk);
    a = 1'b0; b = 1'b1; valid_s[0] = 1'b1;
    check("t4_ready", {7'd0, ready_w[0]}, 8'd1);
    @(posedge clk);
    #1 valid_s[0] = 1'b0;
    @(negedge clk);
    check("t4_settle_busy", {7'd0, busy_w[0]}, 8'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("t4_abort");
    @(negedge clk);
    rst = 1'b0;
    mode[0] = 0;
    do_start(0);
    sweep(0, "t4");
    check("t4_pass", {7'd0, pass_w[0]}, 8'd1);
    check("t4_vc", vc_w[0], 8'd4);
    check("t4_fe", fe_w[0], 8'hFF);

    // Narrow counters, stuck-at-0 gate, all vectors fail
    mode[1] = 2;
    do_start(1);
    send(1, 1'b1, 1'b1, "t5_v0");
    send(1, 1'b1, 1'b1, "t5_v1");
    send(1, 1'b1, 1'b1, "t5_v2");
    check("t5_ec", ec_w[1], 8'd3);
    check("t5_vc", vc_w[1], 8'd3);
    check("t5_fe", fe_w[1], 8'd0);
    check("t5_done", {7'd0, done_w[1]}, 8'd1);
    check("t5_pass", {7'd0, pass_w[1]}, 8'd0);

    // Settle extremes: compare timing seen through err_pulse
    mode[2] = 1; mode[3] = 1;
    do_start(2);
    send(2, 1'b1, 1'b0, "t6s1_v0");
    send(2, 1'b1, 1'b1, "t6s1_v1");
    check("t6s1_ec", ec_w[2], 8'd1);
    check("t6s1_done", {7'd0, done_w[2]}, 8'd1);
    do_start(3);
    send(3, 1'b1, 1'b0, "t6s15_v0");
    send(3, 1'b1, 1'b1, "t6s15_v1");
    check("t6s15_ec", ec_w[3], 8'd1);
    check("t6s15_done", {7'd0, done_w[3]}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
